// File: rtl/letter_display_queue_if.sv
// letter_display_queue_if: processor write, show request and display status bundle
interface letter_display_queue_if;
  logic wr_en;
  logic [4:0] wr_data;
  logic mostrarLetra;
  logic [6:0] segments;
  logic full;
  logic empty;
  logic busy;
  logic overflow;
  modport master(output wr_en, wr_data, mostrarLetra, input segments, full, empty, busy, overflow);
  modport slave(input wr_en, wr_data, mostrarLetra, output segments, full, empty, busy, overflow);
endinterface

// File: rtl/letter_display_queue.sv
// letter_display_queue: FIFO of character codes shown one per show request on a 7-segment display
module letter_display_queue #(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input logic clk,
  input logic reset,
  letter_display_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [4:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic s1, s2, p;
  logic rise, wr, pop;
  logic [6:0] seg_q;
  logic busy_q, ovf_q;
  function automatic logic [6:0] decode(input logic [4:0] c);
    case (c)
      5'h00: decode = 7'b1000000;
      5'h01: decode = 7'b1111001;
      5'h02: decode = 7'b0100100;
      5'h03: decode = 7'b0110000;
      5'h04: decode = 7'b0011001;
      5'h05: decode = 7'b0010010;
      5'h06: decode = 7'b0000010;
      5'h07: decode = 7'b1111000;
      5'h08: decode = 7'b0000000;
      5'h09: decode = 7'b0010000;
      5'h0A: decode = 7'b0001000;
      5'h0B: decode = 7'b0000011;
      5'h0C: decode = 7'b1000110;
      5'h0D: decode = 7'b0100001;
      5'h0E: decode = 7'b0000110;
      5'h0F: decode = 7'b0001110;
      default: decode = 7'b1111111;
    endcase
  endfunction
  assign bus.full = count == (AW+1)'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.segments = seg_q;
  assign bus.busy = busy_q;
  assign bus.overflow = ovf_q;
  assign rise = s2 & ~p;
  assign wr = bus.wr_en & ~bus.full;
  assign pop = (state == IDLE) & rise & ~bus.empty;
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= bus.wr_data;
  // full/empty are pre-edge, so a write racing a pop on a full FIFO is still dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_q <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      seg_q <= 7'b1111111;
      busy_q <= 1'b0;
    end else begin
      s1 <= bus.mostrarLetra;
      s2 <= s1;
      p <= s2;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (bus.wr_en && bus.full) ovf_q <= 1'b1;
      if (state == IDLE) begin
        if (pop) begin
          seg_q <= decode(mem[rd_ptr]);
          cnt <= CW'(HOLD_CYCLES - 1);
          state <= HOLD;
          busy_q <= 1'b1;
        end
      end else if (cnt == '0) begin
        seg_q <= 7'b1111111;
        state <= IDLE;
        busy_q <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_letter_display_queue.sv
// tb_letter_display_queue: directed vectors and corner sequences for letter_display_queue (DEPTH=8, HOLD_CYCLES=4)
module tb_letter_display_queue;
  logic clk, reset;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [4:0] code;
    logic [6:0] seg;
  } vec_t;
  vec_t tv[18];
  letter_display_queue_if b();
  letter_display_queue #(.DEPTH(8), .HOLD_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic write(input logic [4:0] c);
    b.wr_en = 1'b1;
    b.wr_data = c;
    @(posedge clk);
    #1;
    b.wr_en = 1'b0;
  endtask
  task automatic show(input string nm, input logic [6:0] es, input logic eb, input logic w, input logic [4:0] wc);
    b.mostrarLetra = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({nm, "_pre"}, b.segments, 7'h7f);
    if (w) begin
      b.wr_en = 1'b1;
      b.wr_data = wc;
    end
    @(posedge clk);
    #1;
    b.wr_en = 1'b0;
    b.mostrarLetra = 1'b0;
    chk({nm, "_seg"}, b.segments, es);
    chk({nm, "_busy"}, b.busy, eb);
    if (eb) begin
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_held"}, b.busy, 1);
      @(posedge clk);
      #1;
      chk({nm, "_done"}, b.busy, 0);
      chk({nm, "_blank"}, b.segments, 7'h7f);
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask
  initial begin
    tv[0] = '{5'h00, 7'b1000000};
    tv[1] = '{5'h01, 7'b1111001};
    tv[2] = '{5'h02, 7'b0100100};
    tv[3] = '{5'h03, 7'b0110000};
    tv[4] = '{5'h04, 7'b0011001};
    tv[5] = '{5'h05, 7'b0010010};
    tv[6] = '{5'h06, 7'b0000010};
    tv[7] = '{5'h07, 7'b1111000};
    tv[8] = '{5'h08, 7'b0000000};
    tv[9] = '{5'h09, 7'b0010000};
    tv[10] = '{5'h0A, 7'b0001000};
    tv[11] = '{5'h0B, 7'b0000011};
    tv[12] = '{5'h0C, 7'b1000110};
    tv[13] = '{5'h0D, 7'b0100001};
    tv[14] = '{5'h0E, 7'b0000110};
    tv[15] = '{5'h0F, 7'b0001110};
    tv[16] = '{5'h10, 7'b1111111};
    tv[17] = '{5'h1F, 7'b1111111};
    reset = 1'b1;
    b.wr_en = 1'b0;
    b.wr_data = '0;
    b.mostrarLetra = 1'b0;
    #12;
    chk("rst_seg", b.segments, 7'h7f);
    chk("rst_full", b.full, 0);
    chk("rst_empty", b.empty, 1);
    chk("rst_busy", b.busy, 0);
    chk("rst_ovf", b.overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    write(5'h0A);
    chk("wr_empty", b.empty, 0);
    show("first_A", 7'b0001000, 1, 0, 0);
    chk("first_empty", b.empty, 1);
    for (int i = 0; i < 18; i++) begin
      write(tv[i].code);
      show($sformatf("vec%0d", i), tv[i].seg, 1, 0, 0);
    end
    write(5'h03);
    write(5'h07);
    write(5'h0E);
    show("ord0", 7'b0110000, 1, 0, 0);
    show("ord1", 7'b1111000, 1, 0, 0);
    show("ord2", 7'b0000110, 1, 0, 0);
    b.wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b.wr_data = 5'(i);
      @(posedge clk);
      #1;
      if (i == 7) begin
        chk("ovf_full8", b.full, 1);
        chk("ovf_clear8", b.overflow, 0);
      end
    end
    b.wr_en = 1'b0;
    chk("ovf_full9", b.full, 1);
    chk("ovf_set9", b.overflow, 1);
    show("ovf_pop0", tv[0].seg, 1, 1, 5'h0F);
    for (int i = 1; i < 8; i++) show($sformatf("ovf_pop%0d", i), tv[i].seg, 1, 0, 0);
    chk("ovf_drained", b.empty, 1);
    chk("ovf_sticky", b.overflow, 1);
    show("empty_show", 7'h7f, 0, 0, 0);
    write(5'h05);
    write(5'h06);
    b.mostrarLetra = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_seg", b.segments, 7'b0010010);
    chk("hold_busy", b.busy, 1);
    b.mostrarLetra = 1'b0;
    @(posedge clk);
    #1;
    b.mostrarLetra = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_end_busy", b.busy, 0);
    chk("hold_end_seg", b.segments, 7'h7f);
    chk("hold_end_empty", b.empty, 0);
    b.mostrarLetra = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("hold_discard_busy", b.busy, 0);
    chk("hold_discard_seg", b.segments, 7'h7f);
    show("hold_next", 7'b0000010, 1, 0, 0);
    chk("hold_next_empty", b.empty, 1);
    write(5'h0C);
    show("simul", 7'b1000110, 1, 1, 5'h0D);
    chk("simul_count1", b.empty, 0);
    show("simul2", 7'b0100001, 1, 0, 0);
    chk("simul2_empty", b.empty, 1);
    for (int i = 0; i < 20; i++) begin
      write(5'(i % 16));
      show($sformatf("wrap%0d", i), tv[i % 16].seg, 1, 0, 0);
    end
    write(5'h08);
    b.mostrarLetra = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_seg", b.segments, 7'b0000000);
    chk("mid_busy", b.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_seg", b.segments, 7'h7f);
    chk("async_busy", b.busy, 0);
    chk("async_empty", b.empty, 1);
    chk("async_ovf", b.overflow, 0);
    b.mostrarLetra = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    write(5'h02);
    show("resume", 7'b0100100, 1, 0, 0);
    chk("resume_empty", b.empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
